// File: rtl/n_term_pkg.sv
// Shared widths, strobe index and TX state encoding for the
// north-edge terminal stream bridge.
package n_term_pkg;

  localparam int WIRE4_W    = 16;
  localparam int WIRE1_W    = 4;
  localparam int STROBE_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } tx_state_t;

endpackage

// File: rtl/n_term_fifo.sv
// Synchronous show-ahead FIFO; occupancy counter drives full/empty.
// Storage is cleared on reset so the head reads 0 when idle.
module n_term_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [LW-1:0]    level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        mem[wr_q] <= din;
        wr_q      <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout  = mem[rd_q];
  assign level = level_q;
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/n_term_stream_bridge.sv
// North-edge terminal: N4 strobed words into an RX FIFO, TX words
// launched on S4BEG with a one-cycle strobe and a guard gap.
module n_term_stream_bridge
  import n_term_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       UserCLK,
  input  logic                       reset,
  input  logic [WIRE4_W-1:0]         N4END,
  input  logic [WIRE1_W-1:0]         N1END,
  output logic [WIRE4_W-1:0]         rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(DEPTH+1)-1:0] rx_level,
  output logic                       rx_overflow,
  input  logic [WIRE4_W-1:0]         tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [WIRE4_W-1:0]         S4BEG,
  output logic [WIRE1_W-1:0]         S1BEG
);

  localparam logic [2:0] GAP_LOAD =
    3'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  logic strobe;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic ovf_q;

  assign strobe = N1END[STROBE_BIT];
  assign pop    = ~empty & rx_ready;
  assign push   = strobe & (~full | pop);

  n_term_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIRE4_W)
  ) u_fifo (
    .clk   (UserCLK),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (N4END),
    .dout  (rx_data),
    .level (rx_level),
    .full  (full),
    .empty (empty)
  );

  assign rx_valid    = ~empty;
  assign rx_overflow = ovf_q;

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (strobe & full & ~pop) begin
      ovf_q <= 1'b1;
    end
  end

  tx_state_t        state_q;
  tx_state_t        state_d;
  logic [2:0]       gap_q;
  logic [2:0]       gap_d;
  logic             rdy_q;
  logic             stb_q;
  logic [WIRE4_W-1:0] s4_q;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid & rdy_q) state_d = DRIVE;
      end
      DRIVE: begin
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == 3'd0) state_d = IDLE;
        else               gap_d   = gap_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so S4BEG/S1BEG/tx_ready
  // come straight from flops.
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= 3'd0;
      rdy_q   <= 1'b0;
      stb_q   <= 1'b0;
      s4_q    <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rdy_q   <= (state_d == IDLE);
      stb_q   <= (state_d == DRIVE);
      s4_q    <= (state_d == DRIVE) ? tx_data : '0;
    end
  end

  always_comb begin
    S1BEG             = '0;
    S1BEG[STROBE_BIT] = stb_q;
  end

  assign S4BEG    = s4_q;
  assign tx_ready = rdy_q;

endmodule

// File: tb/tb_n_term_stream_bridge.sv
// Directed plus randomized bench for n_term_stream_bridge with a
// queue-based RX model and a countdown TX model.
module tb_n_term_stream_bridge;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int LW    = $clog2(DEPTH+1);

  logic          UserCLK = 1'b0;
  logic          reset;
  logic [15:0]   N4END;
  logic [3:0]    N1END;
  logic [15:0]   rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [LW-1:0] rx_level;
  logic          rx_overflow;
  logic [15:0]   tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [15:0]   S4BEG;
  logic [3:0]    S1BEG;

  n_term_stream_bridge #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .UserCLK     (UserCLK),
    .reset       (reset),
    .N4END       (N4END),
    .N1END       (N1END),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_level    (rx_level),
    .rx_overflow (rx_overflow),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .S4BEG       (S4BEG),
    .S1BEG       (S1BEG)
  );

  always #5 UserCLK = ~UserCLK;

  int checks = 0;
  int errors = 0;

  logic [15:0] q[$];
  bit          m_ovf;
  bit          m_rdy;
  logic [15:0] m_s4;
  bit          m_s1;
  int          m_wait;
  logic [15:0] last_pop;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input logic [3:0] n1,
                      input logic [15:0] n4, input bit rrdy,
                      input bit tv, input logic [15:0] td);
    bit popm;
    bit fullm;
    reset    = rst;
    N1END    = n1;
    N4END    = n4;
    rx_ready = rrdy;
    tx_valid = tv;
    tx_data  = td;
    if (rst) begin
      q.delete();
      m_ovf  = 0;
      m_rdy  = 0;
      m_s4   = '0;
      m_s1   = 0;
      m_wait = 0;
    end else begin
      popm  = (q.size() != 0) && rrdy;
      fullm = (q.size() == DEPTH);
      if (popm) last_pop = q.pop_front();
      if (n1[0]) begin
        if (!fullm || popm) q.push_back(n4);
        else m_ovf = 1;
      end
      if (m_rdy && tv) begin
        m_s4   = td;
        m_s1   = 1;
        m_rdy  = 0;
        m_wait = 1 + GAP;
      end else begin
        m_s4 = '0;
        m_s1 = 0;
        if (m_wait > 0) m_wait--;
        m_rdy = (m_wait == 0);
      end
    end
    @(posedge UserCLK);
    #1;
    chk("rx_valid", 32'(rx_valid), 32'(q.size() != 0));
    chk("rx_level", 32'(rx_level), 32'(q.size()));
    chk("rx_overflow", 32'(rx_overflow), 32'(m_ovf));
    if (q.size() != 0) chk("rx_data", 32'(rx_data), 32'(q[0]));
    else if (rst) chk("rx_data_rst", 32'(rx_data), 32'h0);
    chk("tx_ready", 32'(tx_ready), 32'(m_rdy));
    chk("S4BEG", 32'(S4BEG), 32'(m_s4));
    chk("S1BEG", 32'(S1BEG), {31'h0, m_s1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 16'h0, 0, 0, 16'h0);
  endtask

  initial begin
    reset = 1; N1END = 0; N4END = 0;
    rx_ready = 0; tx_valid = 0; tx_data = 0;
    last_pop = '0;
    step(1, 4'h0, 16'h0, 0, 0, 16'h0);
    step(1, 4'h0, 16'h0, 0, 0, 16'h0);
    idle(1);

    // single word in and out
    step(0, 4'h1, 16'hA5A5, 0, 0, 16'h0);
    step(0, 4'h0, 16'h0, 1, 0, 16'h0);
    chk("pop_A5A5", 32'(last_pop), 32'hA5A5);

    // fill past capacity, then drain in order
    for (int i = 1; i <= 5; i++) step(0, 4'h1, 16'(i), 0, 0, 16'h0);
    chk("ovf_set", 32'(rx_overflow), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 4'h0, 16'h0, 1, 0, 16'h0);
      chk("drain_order", 32'(last_pop), 32'(i));
    end

    // full with simultaneous push and pop
    step(1, 4'h0, 16'h0, 0, 0, 16'h0);
    for (int i = 1; i <= 4; i++) step(0, 4'h1, 16'(i), 0, 0, 16'h0);
    step(0, 4'h1, 16'h00FF, 1, 0, 16'h0);
    chk("full_pp_level", 32'(rx_level), 32'h4);
    chk("full_pp_ovf", 32'(rx_overflow), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 4'h0, 16'h0, 1, 0, 16'h0);
    chk("last_is_FF", 32'(last_pop), 32'h00FF);

    // back-to-back TX with held valid
    step(0, 4'h0, 16'h0, 0, 1, 16'h1234);
    for (int i = 0; i < 3; i++) step(0, 4'h0, 16'h0, 0, 1, 16'h5678);
    step(0, 4'h0, 16'h0, 0, 1, 16'h5678);
    idle(5);

    // reset during DRIVE with 3 words queued
    for (int i = 0; i < 3; i++) step(0, 4'h1, 16'hC0 + 16'(i), 0, 0, 16'h0);
    step(0, 4'h0, 16'h0, 0, 1, 16'hBEEF);
    step(1, 4'h0, 16'h0, 0, 0, 16'h0);
    step(0, 4'h0, 16'h0, 0, 0, 16'h0);
    chk("rdy_after_rel", 32'(tx_ready), 32'h1);

    // strobe and TX handshake in the same cycle
    step(0, 4'hF, 16'h3C3C, 0, 1, 16'h9999);
    step(0, 4'h0, 16'h0, 1, 0, 16'h0);
    chk("both_rx", 32'(last_pop), 32'h3C3C);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0),
           4'($urandom),
           16'($urandom),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 1) != 0),
           16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
